// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also consumed by decode.
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned XLEN       = 32;

    // Canonical NOP (addi x0, x0, 0) used when decode squashes a slot.
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Flush wins over a same-cycle push so squashed data never becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited in-order memory requests,
// PC-tagged instruction queue and branch redirect with wrong-path squashing.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_taken,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [CNT_W-1:0]      drop_cnt_q;
    logic [CNT_W-1:0]      drop_cnt_d;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      occupancy;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [ENTRY_W-1:0]    iq_head;
    logic                  iq_full;
    logic                  iq_empty;
    logic                  pq_full;
    logic                  pq_empty;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  rsp_keep;
    logic                  pop_fire;

    // Credit covers both in-flight requests and queued instructions, so the queue never overflows.
    assign imem_req_valid = !rst && ((32'(outstanding) + 32'(occupancy)) < FIFO_DEPTH);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep       = rsp_fire && (drop_cnt_q == '0);

    assign inst_valid = !iq_empty;
    assign inst       = iq_head[ENTRY_W-1 -: DATA_WIDTH];
    assign inst_pc    = iq_head[ADDR_WIDTH-1:0];
    assign pop_fire   = inst_valid && inst_ready;

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (req_fire) begin
            pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
        end
        if (rsp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        // Everything still in flight after this cycle belongs to the old path.
        if (br_taken) begin
            pc_d       = br_target & ~ADDR_WIDTH'(INST_BYTES - 1);
            drop_cnt_d = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_keep),
        .push_data_i ({imem_rsp_data, rsp_pc}),
        .pop_i       (pop_fire),
        .flush_i     (br_taken),
        .head_o      (iq_head),
        .full_o      (iq_full),
        .empty_o     (iq_empty),
        .count_o     (occupancy)
    );

    // Outstanding-request PC record; its count is the outstanding counter.
    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_req_pc_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (rsp_fire),
        .flush_i     (1'b0),
        .head_o      (rsp_pc),
        .full_o      (pq_full),
        .empty_o     (pq_empty),
        .count_o     (outstanding)
    );

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> !pq_empty);
    a_req_record_room: assert property (@(posedge clk) disable iff (rst)
        req_fire |-> !pq_full);
    a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        rsp_keep |-> !iq_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: behavioural in-order memory plus expected-instruction queue.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mem_q[$];
    fetch_entry_t exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           lat = 1;
    int           delivered = 0;
    int           hs_cnt = 0;
    int           drop_exp = 0;
    logic [31:0]  exp_pc = RESET_PC;
    logic [31:0]  last_pc = 32'h1;
    bit           mem_hold = 0;
    bit           stray = 0;
    bit           arm8 = 0;
    bit           hit8 = 0;
    bit           wrap_seen = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at posedge+1, observe at negedge, then advance to the next posedge+1.
    task automatic tick(input logic br, input logic [31:0] tgt);
        logic         b;
        logic [31:0]  t;
        logic         rsp_drv;
        fetch_entry_t e;
        b       = br;
        t       = tgt;
        rsp_drv = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q[0].addr);
            rsp_drv        = 1'b1;
        end
        if (arm8 && rsp_drv && mem_q[0].addr == 32'h4 && imem_req_valid && imem_req_ready
            && imem_req_addr == 32'h8) begin
            b    = 1'b1;
            t    = 32'h200;
            arm8 = 0;
            hit8 = 1;
        end
        br_taken  = b;
        br_target = t;
        @(negedge clk);
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_pc = RESET_PC;
        end else begin
            if (inst_valid && inst_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_inst", 32'(inst_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("inst_pc", inst_pc, e.pc);
                    check_eq("inst", inst, e.inst);
                end
                if (inst_pc == 32'h0 && last_pc == 32'hFFFF_FFFC) wrap_seen = 1;
                last_pc = inst_pc;
            end
            if (rsp_drv) mem_q.delete(0);
            if (imem_req_valid && imem_req_ready) begin
                check_eq("req_addr", imem_req_addr, exp_pc);
                mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                exp_q.push_back('{inst: mem_data(exp_pc), pc: exp_pc});
                exp_pc = exp_pc + 32'd4;
                hs_cnt++;
            end
            if (b) begin
                exp_q.delete();
                exp_pc   = t & ~32'h3;
                drop_exp = mem_q.size();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        br_taken = 1'b0;
        if (b && !rst) begin
            check_eq("redir_addr", imem_req_addr, t & ~32'h3);
            check_eq("redir_flush", 32'(inst_valid), 32'h0);
            check_eq("drop_cnt", 32'(dut.drop_cnt_q), 32'(drop_exp));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
    endtask

    // Stop issuing and let every expected instruction come out, bounded.
    task automatic drain();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 60 && (exp_q.size() > 0 || mem_q.size() > 0); i++) tick(1'b0, 32'h0);
        check_eq("drain_left", 32'(exp_q.size() + mem_q.size()), 32'h0);
        imem_req_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int h0;
        rst            = 1'b1;
        br_taken       = 1'b0;
        br_target      = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b1;
        @(posedge clk);
        #1;
        run(3);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);

        // Free-run after reset at 1-cycle memory latency.
        rst = 1'b0;
        #1;
        check_eq("first_req_valid", 32'(imem_req_valid), 32'h1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
        d0 = delivered;
        run(40);
        check_eq("freerun_rate", 32'((delivered - d0) >= 20), 32'h1);
        drain();

        // Redirect coinciding with request at 0x8 and response for 0x4.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2);
        mem_hold = 1;
        run(1);
        mem_hold = 0;
        arm8     = 1;
        run(3);
        arm8 = 0;
        check_eq("hit8_seen", 32'(hit8), 32'h1);
        run(8);
        drain();

        // Decode stalled: credit stops the request stream at two.
        inst_ready = 1'b0;
        h0         = hs_cnt;
        run(10);
        check_eq("stall_reqs", 32'(hs_cnt - h0), 32'h2);
        check_eq("stall_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("stall_inst_valid", 32'(inst_valid), 32'h1);
        inst_ready = 1'b1;
        run(10);
        drain();

        // Redirect with two requests in flight.
        mem_hold = 1;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) tick(1'b0, 32'h0);
        check_eq("two_outstanding", 32'(mem_q.size()), 32'h2);
        tick(1'b1, 32'h100);
        mem_hold = 0;
        run(10);
        drain();

        // Misaligned target and address wrap.
        tick(1'b1, 32'h103);
        check_eq("misalign_addr", imem_req_addr, 32'h100);
        run(8);
        tick(1'b1, 32'hFFFF_FFF4);
        run(14);
        drain();
        check_eq("wrap_seen", 32'(wrap_seen), 32'h1);

        // Reset with a full queue, plus a stray response while in reset.
        inst_ready = 1'b0;
        mem_hold   = 1;
        run(6);
        mem_hold = 0;
        run(3);
        rst   = 1'b1;
        stray = 1;
        run(1);
        stray = 0;
        run(2);
        check_eq("midrst_inst_valid", 32'(inst_valid), 32'h0);
        check_eq("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        inst_ready = 1'b1;
        rst        = 1'b0;
        #1;
        check_eq("restart_addr", imem_req_addr, RESET_PC);
        check_eq("restart_valid", 32'(imem_req_valid), 32'h1);
        run(12);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
